// File: rtl/apb_chk_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | apb_chk_pkg                                                              |
// | Shared phase encoding, error-bit indices and helpers for the APB checker |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
package apb_chk_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } apb_phase_e;

  localparam int ERR_PSEL_MULTI  = 0;
  localparam int ERR_EN_NO_SETUP = 1;
  localparam int ERR_NO_ACCESS   = 2;
  localparam int ERR_UNSTABLE    = 3;
  localparam int ERR_EN_STUCK    = 4;
  localparam int ERR_TIMEOUT     = 5;
  localparam int ERR_PSTRB       = 6;
  localparam int NUM_ERR         = 7;

  // True when at most one bit of v is set.
  function automatic logic onehot0(input logic [15:0] v);
    return ((v & (v - 16'd1)) == 16'd0);
  endfunction

endpackage
`default_nettype wire

// File: rtl/apb_sat_counter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | apb_sat_counter                                                          |
// | Saturating event counter; a same-cycle clr and inc restart the count at 1|
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module apb_sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             PCLK,
  input  logic             PRESET,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] cnt
);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      r_cnt <= '0;
    end else if (clr) begin
      r_cnt <= CNT_W'(inc);
    end else if (inc && (r_cnt != '1)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign cnt = r_cnt;

endmodule
`default_nettype wire

// File: rtl/apb_protocol_checker.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | apb_protocol_checker                                                     |
// | Passive APB3/APB4 requester-side checker: phase tracking, registered     |
// | violation pulses, sticky/first-error record and transfer counters.       |
// | Optional PSTRB check: define APB_PSTRB_CHECK_EN.                         |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module apb_protocol_checker
  import apb_chk_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_SLV    = 2,
  parameter int TIMEOUT    = 16,
  parameter int CNT_W      = 16
) (
  input  logic                    PCLK,
  input  logic                    PRESET,
  input  logic [NUM_SLV-1:0]      PSEL,
  input  logic                    PENABLE,
  input  logic                    PWRITE,
  input  logic [ADDR_WIDTH-1:0]   PADDR,
  input  logic [DATA_WIDTH-1:0]   PWDATA,
  input  logic                    PREADY,
  input  logic                    PSLVERR,
`ifdef APB_PSTRB_CHECK_EN
  input  logic [DATA_WIDTH/8-1:0] PSTRB,
`endif
  input  logic                    clr,
  output logic [NUM_ERR-1:0]      err_pulse,
  output logic [NUM_ERR-1:0]      err_sticky,
  output logic                    err_first_valid,
  output logic [2:0]              err_first_code,
  output logic [CNT_W-1:0]        wr_cnt,
  output logic [CNT_W-1:0]        rd_cnt,
  output logic [CNT_W-1:0]        slverr_cnt
);

  localparam int c_WAIT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  // r_state is the phase of the last sampled cycle; r_done marks an ACCESS
  // cycle that completed, so the next cycle is judged as a post-transfer cycle.
  apb_phase_e            r_state;
  logic                  r_done;
  logic [NUM_SLV-1:0]    r_psel;
  logic                  r_pwrite;
  logic [ADDR_WIDTH-1:0] r_paddr;
  logic [DATA_WIDTH-1:0] r_pwdata;
  logic [c_WAIT_W-1:0]   r_wait;
  logic                  r_to_fired;
  logic [NUM_ERR-1:0]    r_err_pulse;
  logic [NUM_ERR-1:0]    r_err_sticky;
  logic                  r_first_valid;
  logic [2:0]            r_first_code;

  logic                  w_sel_any;
  logic                  w_idle_like;
  logic                  w_in_access;
  logic                  w_ctrl_diff;
  logic                  w_resync;
  logic                  w_setup_start;
  logic                  w_complete;
  logic [c_WAIT_W-1:0]   w_wait_inc;
  logic                  w_err6;
  logic [NUM_ERR-1:0]    w_err;
  logic [2:0]            w_first_idx;

  assign w_sel_any   = |PSEL;
  assign w_idle_like = (r_state == IDLE) || ((r_state == ACCESS) && r_done);
  assign w_in_access = (r_state == SETUP) || ((r_state == ACCESS) && !r_done);
  assign w_ctrl_diff = (PWRITE != r_pwrite) || (PADDR != r_paddr) ||
                       (r_pwrite && (PWDATA != r_pwdata));
  assign w_wait_inc  = r_wait + 1'b1;

`ifdef APB_PSTRB_CHECK_EN
  logic [DATA_WIDTH/8-1:0] r_pstrb;

  assign w_err6 = (w_setup_start && !PWRITE && (PSTRB != '0)) ||
                  (w_in_access && ((!r_pwrite && (PSTRB != '0)) || (PSTRB != r_pstrb)));

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      r_pstrb <= '0;
    end else if (w_setup_start || (w_resync && w_sel_any && !w_err[ERR_PSEL_MULTI])) begin
      r_pstrb <= PSTRB;
    end
  end
`else
  assign w_err6 = 1'b0;
`endif

  always_comb begin
    w_err = '0;
    w_err[ERR_PSEL_MULTI]  = !onehot0(16'(PSEL));
    w_err[ERR_EN_NO_SETUP] = (r_state == IDLE) && PENABLE;
    w_err[ERR_NO_ACCESS]   = (r_state == SETUP) && (!PENABLE || (PSEL != r_psel));
    w_err[ERR_UNSTABLE]    = ((r_state == SETUP) && PENABLE && w_ctrl_diff) ||
                             ((r_state == ACCESS) && !r_done && ((PSEL != r_psel) || w_ctrl_diff));
    w_err[ERR_EN_STUCK]    = (r_state == ACCESS) && r_done && PENABLE;
    w_err[ERR_TIMEOUT]     = (TIMEOUT != 0) && w_in_access && !w_resync && !PREADY &&
                             !r_to_fired && (w_wait_inc == c_WAIT_W'(TIMEOUT));
    w_err[ERR_PSTRB]       = w_err6;
  end

  // A malformed multi-select never opens a transfer to track.
  assign w_resync      = w_err[ERR_NO_ACCESS] | w_err[ERR_UNSTABLE] | w_err[ERR_EN_STUCK];
  assign w_setup_start = w_idle_like && !w_resync && w_sel_any && !PENABLE &&
                         !w_err[ERR_PSEL_MULTI];
  assign w_complete    = w_in_access && !w_resync && PREADY;

  always_comb begin
    w_first_idx = 3'd0;
    for (int i = NUM_ERR - 1; i >= 0; i--) begin
      if (w_err[i]) w_first_idx = 3'(i);
    end
  end

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      r_state    <= IDLE;
      r_done     <= 1'b0;
      r_psel     <= '0;
      r_pwrite   <= 1'b0;
      r_paddr    <= '0;
      r_pwdata   <= '0;
      r_wait     <= '0;
      r_to_fired <= 1'b0;
    end else if (w_resync) begin
      r_wait     <= '0;
      r_to_fired <= 1'b0;
      if (!w_sel_any || w_err[ERR_PSEL_MULTI]) begin
        r_state <= IDLE;
        r_done  <= 1'b0;
      end else begin
        r_psel   <= PSEL;
        r_pwrite <= PWRITE;
        r_paddr  <= PADDR;
        if (PWRITE) r_pwdata <= PWDATA;
        r_state  <= PENABLE ? ACCESS : SETUP;
        r_done   <= PENABLE && PREADY;
      end
    end else if (w_in_access) begin
      r_state <= ACCESS;
      r_done  <= PREADY;
      if (PREADY) begin
        r_wait     <= '0;
        r_to_fired <= 1'b0;
      end else if ((TIMEOUT != 0) && !r_to_fired) begin
        r_wait <= w_wait_inc;
        if (w_wait_inc == c_WAIT_W'(TIMEOUT)) r_to_fired <= 1'b1;
      end
    end else begin
      r_done <= 1'b0;
      if (w_setup_start) begin
        r_state  <= SETUP;
        r_psel   <= PSEL;
        r_pwrite <= PWRITE;
        r_paddr  <= PADDR;
        if (PWRITE) r_pwdata <= PWDATA;
      end else begin
        r_state <= IDLE;
      end
    end
  end

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      r_err_pulse   <= '0;
      r_err_sticky  <= '0;
      r_first_valid <= 1'b0;
      r_first_code  <= 3'd0;
    end else begin
      r_err_pulse  <= w_err;
      r_err_sticky <= (clr ? '0 : r_err_sticky) | w_err;
      if ((|w_err) && (clr || !r_first_valid)) begin
        r_first_valid <= 1'b1;
        r_first_code  <= w_first_idx;
      end else if (clr) begin
        r_first_valid <= 1'b0;
        r_first_code  <= 3'd0;
      end
    end
  end

  apb_sat_counter #(.CNT_W(CNT_W)) u_wr_cnt (
    .PCLK   (PCLK),
    .PRESET (PRESET),
    .inc    (w_complete && PWRITE),
    .clr    (clr),
    .cnt    (wr_cnt)
  );

  apb_sat_counter #(.CNT_W(CNT_W)) u_rd_cnt (
    .PCLK   (PCLK),
    .PRESET (PRESET),
    .inc    (w_complete && !PWRITE),
    .clr    (clr),
    .cnt    (rd_cnt)
  );

  apb_sat_counter #(.CNT_W(CNT_W)) u_slverr_cnt (
    .PCLK   (PCLK),
    .PRESET (PRESET),
    .inc    (w_complete && PSLVERR),
    .clr    (clr),
    .cnt    (slverr_cnt)
  );

  assign err_pulse       = r_err_pulse;
  assign err_sticky      = r_err_sticky;
  assign err_first_valid = r_first_valid;
  assign err_first_code  = r_first_code;

endmodule
`default_nettype wire
